// File: rtl/soc_system_pio_pkg.sv
// Shared address map, CTRL/STAT bit positions and counter width for the multi-channel PIO.
// Latency: n/a (constants only). Backpressure: n/a.
// Offsets are functions of the channel count so every PIO variant shares one map.
package soc_system_pio_pkg;

    localparam int COUNT_W      = 16;

    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_CLR_OVR = 1;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVR     = 1;

    function automatic int ofs_ctrl(input int num_ch);
        return num_ch;
    endfunction

    function automatic int ofs_count(input int num_ch);
        return num_ch + 1;
    endfunction

endpackage

// File: rtl/soc_system_pio_mc_out_if.sv
// Avalon-MM slave bus plus committed-output handshake of the multi-channel output PIO.
// Latency: n/a (wiring only). Backpressure: out_valid is held until out_ack.
// The master modport is the HPS/consumer side; slave is the PIO itself.
interface soc_system_pio_mc_out_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0]        address;
    logic                     chipselect;
    logic                     write_n;
    logic [DATA_W/8-1:0]      byteenable;
    logic [DATA_W-1:0]        writedata;
    logic [DATA_W-1:0]        readdata;
    logic [NUM_CH*DATA_W-1:0] out_port;
    logic                     out_valid;
    logic                     out_ack;

    modport master (
        output address, chipselect, write_n, byteenable, writedata, out_ack,
        input  readdata, out_port, out_valid
    );

    modport slave (
        input  address, chipselect, write_n, byteenable, writedata, out_ack,
        output readdata, out_port, out_valid
    );
endinterface

// File: rtl/soc_system_pio_be_reg.sv
// DATA_W register with per-byte write enables and synchronous reset to RESET_VAL.
// Latency: 1 cycle write-to-q. Backpressure: none, writes always accepted.
// Reset has priority over a concurrent write.
module soc_system_pio_be_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be[i]) q[i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/soc_system_pio_mc_out.sv
// Multi-channel output PIO: byte-enabled shadows, atomic commit to out_port, overrun flag, commit counter.
// Latency: commit visible on out_port/out_valid 1 cycle after the write edge; readdata is combinational.
// Backpressure: out_valid holds until out_ack; a commit while busy without ack is dropped and flags overrun.
module soc_system_pio_mc_out
    import soc_system_pio_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    soc_system_pio_mc_out_if.slave  bus
);

    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(ofs_ctrl(NUM_CH));
    localparam logic [ADDR_W-1:0] A_COUNT = ADDR_W'(ofs_count(NUM_CH));

    logic                     wr;
    logic                     is_ctrl;
    logic                     commit_req;
    logic                     clr_req;
    logic                     accept;
    logic                     reject;
    logic [NUM_CH*DATA_W-1:0] shadow_flat;
    logic [NUM_CH*DATA_W-1:0] out_port_q;
    logic                     busy;
    logic                     overrun;
    logic [COUNT_W-1:0]       commit_cnt;
    logic [31:0]              cnt_ext;
    logic [DATA_W-1:0]        readdata_c;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign is_ctrl    = wr && (bus.address == A_CTRL) && bus.byteenable[0];
    assign commit_req = is_ctrl & bus.writedata[CTRL_COMMIT];
    assign clr_req    = is_ctrl & bus.writedata[CTRL_CLR_OVR];
    // An ack in the same cycle frees the slot, so the new commit is taken back-to-back.
    assign accept     = commit_req & (~busy | bus.out_ack);
    assign reject     = commit_req & busy & ~bus.out_ack;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic ch_we;
        assign ch_we = wr && (bus.address == ADDR_W'(k));

        soc_system_pio_be_reg #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_shadow (
            .clk   (clk),
            .reset (reset),
            .we    (ch_we),
            .be    (bus.byteenable),
            .wdata (bus.writedata),
            .q     (shadow_flat[k*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port_q <= {NUM_CH{RESET_VAL}};
            busy       <= 1'b0;
            overrun    <= 1'b0;
            commit_cnt <= '0;
        end else begin
            if (accept) begin
                out_port_q <= shadow_flat;
                busy       <= 1'b1;
                commit_cnt <= commit_cnt + 1'b1;
            end else if (busy && bus.out_ack) begin
                busy <= 1'b0;
            end

            // A rejected commit beats a clear carried in the same write.
            if (reject) begin
                overrun <= 1'b1;
            end else if (clr_req) begin
                overrun <= 1'b0;
            end
        end
    end

    assign cnt_ext = 32'(commit_cnt);

    always_comb begin
        readdata_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.address == ADDR_W'(k)) readdata_c = shadow_flat[k*DATA_W +: DATA_W];
        end
        if (bus.address == A_CTRL) begin
            readdata_c[STAT_BUSY] = busy;
            readdata_c[STAT_OVR]  = overrun;
        end
        if (bus.address == A_COUNT) readdata_c = cnt_ext[DATA_W-1:0];
    end

    assign bus.readdata  = readdata_c;
    assign bus.out_port  = out_port_q;
    assign bus.out_valid = busy;

endmodule

// File: tb/tb_soc_system_pio_mc_out.sv
// Directed scoreboard bench for soc_system_pio_mc_out: stimulus queues expectations, a negedge monitor checks them.
// Latency: n/a. Backpressure: n/a.
module tb_soc_system_pio_mc_out;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam int K_RD    = 0;
    localparam int K_PORT  = 1;
    localparam int K_VALID = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [63:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_vld = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    soc_system_pio_mc_out_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    soc_system_pio_mc_out #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per flagged cycle and compares on the falling edge.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_underflow: got no expectation, required one");
            end else begin
                exp_t e;
                logic [63:0] act;
                e = sb.pop_front();
                case (e.kind)
                    K_RD:    act = {32'h0, bus.readdata};
                    K_PORT:  act = bus.out_port;
                    default: act = {63'h0, bus.out_valid};
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h required %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic wr_op(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d, input logic ack);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = d;
        bus.out_ack    = ack;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.out_ack    = 1'b0;
    endtask

    task automatic ack_op();
        bus.out_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ack = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [2:0] a, input logic [63:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = exp;
        bus.address = a;
        sb.push_back(e);
        chk_vld = 1'b1;
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.byteenable = '0;
        bus.writedata  = '0;
        bus.out_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state across the whole map
        chk(K_RD, 3'd0, 64'h0, "rst_shadow0");
        chk(K_RD, 3'd1, 64'h0, "rst_shadow1");
        chk(K_RD, 3'd2, 64'h0, "rst_stat");
        chk(K_RD, 3'd3, 64'h0, "rst_count");
        for (int a = 4; a < 8; a++) chk(K_RD, 3'(a), 64'h0, "rst_unmapped");
        chk(K_PORT, 3'd0, 64'h0, "rst_out_port");
        chk(K_VALID, 3'd0, 64'h0, "rst_out_valid");

        // Byte-lane merge into shadow 0
        wr_op(3'd0, 4'b1111, 32'h11223344, 1'b0);
        wr_op(3'd0, 4'b0101, 32'hAABBCCDD, 1'b0);
        chk(K_RD, 3'd0, 64'h11BB33DD, "be_merge");
        chk(K_PORT, 3'd0, 64'h0, "port_untouched_by_shadow");

        // First commit from idle
        wr_op(3'd0, 4'b1111, 32'hDEADBEEF, 1'b0);
        wr_op(3'd1, 4'b1111, 32'h0000CAFE, 1'b0);
        wr_op(3'd2, 4'b0001, 32'h1, 1'b0);
        chk(K_PORT, 3'd0, 64'h0000CAFE_DEADBEEF, "commit1_port");
        chk(K_VALID, 3'd0, 64'h1, "commit1_valid");
        chk(K_RD, 3'd3, 64'h1, "commit1_count");
        chk(K_RD, 3'd2, 64'h1, "commit1_stat");

        // Rejected commit while busy, then clear paths
        wr_op(3'd0, 4'b1111, 32'h12345678, 1'b0);
        wr_op(3'd1, 4'b1111, 32'h9ABCDEF0, 1'b0);
        wr_op(3'd2, 4'b0001, 32'h1, 1'b0);
        chk(K_PORT, 3'd0, 64'h0000CAFE_DEADBEEF, "overrun_port_held");
        chk(K_RD, 3'd2, 64'h3, "overrun_stat");
        chk(K_RD, 3'd3, 64'h1, "overrun_count");
        wr_op(3'd2, 4'b1110, 32'h2, 1'b0);
        chk(K_RD, 3'd2, 64'h3, "clr_needs_be0");
        wr_op(3'd2, 4'b0001, 32'h2, 1'b0);
        chk(K_RD, 3'd2, 64'h1, "clr_ovr");
        ack_op();
        chk(K_RD, 3'd2, 64'h0, "ack_stat");
        chk(K_VALID, 3'd0, 64'h0, "ack_valid");
        chk(K_PORT, 3'd0, 64'h0000CAFE_DEADBEEF, "ack_port_held");
        ack_op();
        chk(K_RD, 3'd2, 64'h0, "idle_ack_ignored");

        // Commit from idle, then a commit coinciding with ack
        wr_op(3'd2, 4'b0001, 32'h1, 1'b0);
        chk(K_PORT, 3'd0, 64'h9ABCDEF0_12345678, "commit2_port");
        chk(K_RD, 3'd3, 64'h2, "commit2_count");
        wr_op(3'd0, 4'b1111, 32'hCAFEF00D, 1'b0);
        wr_op(3'd2, 4'b0001, 32'h1, 1'b1);
        chk(K_PORT, 3'd0, 64'h9ABCDEF0_CAFEF00D, "ack_commit_port");
        chk(K_VALID, 3'd0, 64'h1, "ack_commit_valid");
        chk(K_RD, 3'd3, 64'h3, "ack_commit_count");
        chk(K_RD, 3'd2, 64'h1, "ack_commit_stat");

        // Commit without byte lane 0 is no commit at all
        wr_op(3'd2, 4'b1110, 32'h1, 1'b0);
        chk(K_RD, 3'd2, 64'h1, "commit_needs_be0");
        // Rejected commit and clear in one write: set wins
        wr_op(3'd2, 4'b0001, 32'h3, 1'b0);
        chk(K_RD, 3'd2, 64'h3, "set_beats_clear");
        wr_op(3'd2, 4'b0001, 32'h2, 1'b0);
        wr_op(3'd3, 4'b1111, 32'hFFFF, 1'b0);
        chk(K_RD, 3'd3, 64'h3, "count_readonly");
        wr_op(3'd5, 4'b1111, 32'hFFFFFFFF, 1'b0);
        chk(K_RD, 3'd5, 64'h0, "unmapped_write");

        // Back-to-back commit+ack burst takes the counter to 0xFFFF
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 3'd2;
        bus.byteenable = 4'b0001;
        bus.writedata  = 32'h1;
        bus.out_ack    = 1'b1;
        repeat (16'hFFFF - 3) @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.out_ack    = 1'b0;
        chk(K_RD, 3'd3, 64'hFFFF, "count_ffff");
        wr_op(3'd2, 4'b0001, 32'h1, 1'b1);
        chk(K_RD, 3'd3, 64'h0, "count_wrap");
        chk(K_VALID, 3'd0, 64'h1, "wrap_valid");

        // Reset while busy, with a shadow write in flight
        reset          = 1'b1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 3'd0;
        bus.byteenable = 4'b1111;
        bus.writedata  = 32'h55555555;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk(K_VALID, 3'd0, 64'h0, "rst_busy_valid");
        chk(K_PORT, 3'd0, 64'h0, "rst_busy_port");
        chk(K_RD, 3'd2, 64'h0, "rst_busy_stat");
        chk(K_RD, 3'd0, 64'h0, "rst_write_discarded");
        chk(K_RD, 3'd3, 64'h0, "rst_busy_count");

        @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
